// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the two requester ports and the memory port of
// mem_arbiter.
//   slave  modport: the arbiter's view (takes requests and mem_rdata, drives
//                   acks, read data, memory controls, busy, gnt_id)
//   master modport: the environment's view (requesters plus memory)
//
// Handshake: reqN is a level request that the requester keeps asserted, with
// weN/addrN/wdataN stable, until ackN pulses for one cycle. The arbiter samples
// requests only while idle. rdataN is meaningful only in the ack cycle of a
// read. If reqN is still high after its ack, it counts as a new request.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          gnt_id;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata,
           busy, gnt_id
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata,
           busy, gnt_id
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester, round-robin arbiter in front of a single-port
// synchronous memory with a fixed read latency. One access is in flight at a
// time, sequenced by an IDLE -> ISSUE -> (WAIT) -> RESP state machine.
// Ports:
//   clk          clock, all state on posedge
//   rstb         asynchronous active-low reset
//   bus          mem_arbiter_if.slave: requester ports, memory port, busy, gnt_id
//   o_dbg_state  current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
module mem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rstb,
  mem_arbiter_if.slave      bus,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // WAIT lasts READ_LATENCY cycles; the counter hits zero in the last one.
  localparam logic [3:0] LP_CNT_INIT = 4'(READ_LATENCY - 1);

  state_t        r_state;
  state_t        w_next;
  logic          r_last_gnt;
  logic          r_id;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic [3:0]    r_cnt;
  logic          w_any_req;
  logic          w_gnt;

  assign w_any_req = bus.req0 | bus.req1;
  // On a tie the requester that was not served last wins; a lone requester
  // always wins regardless of history.
  assign w_gnt = (bus.req0 & bus.req1) ? ~r_last_gnt : bus.req1;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_next = S_ISSUE;
      S_ISSUE: w_next = r_we ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_last_gnt <= 1'b1;
      r_id       <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_cnt      <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_id    <= w_gnt;
            r_we    <= w_gnt ? bus.we1    : bus.we0;
            r_addr  <= w_gnt ? bus.addr1  : bus.addr0;
            r_wdata <= w_gnt ? bus.wdata1 : bus.wdata0;
          end
        end
        S_ISSUE: begin
          if (!r_we) r_cnt <= LP_CNT_INIT;
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) r_rdata <= bus.mem_rdata;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_RESP: begin
          r_last_gnt <= r_id;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_en    = (r_state == S_ISSUE);
  assign bus.mem_we    = (r_state == S_ISSUE) & r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.ack0      = (r_state == S_RESP) & ~r_id;
  assign bus.ack1      = (r_state == S_RESP) &  r_id;
  assign bus.rdata0    = r_rdata;
  assign bus.rdata1    = r_rdata;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.gnt_id    = (r_state != S_IDLE) & r_id;
  assign o_dbg_state   = r_state;

endmodule
